eight_bus_arbiter: RTL and testbench

EIGHT_BUS_ARBITER -- requirements
Module: eight_bus_arbiter

---
 rtl/eight_bus_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 21 ++
 rtl/eight_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_eight_bus_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eight_bus_pkg.sv
// Shared types and defaults for the two-requester byte bus arbiter.
`timescale 1ns/1ps
package eight_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone request always wins, a tie goes to the
// requester that was not served last.
`timescale 1ns/1ps
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic       grant_id,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
        grant_id    = 1'b0;
        if (req == 2'b11) begin
            grant_id = ~last_served;
        end else if (req[1]) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/eight_bus_arbiter.sv
// Arbitrates two byte requesters onto one downstream bus interface with a
// one-cycle issue strobe, bounded ready wait and sticky error reporting.
`timescale 1ns/1ps
module eight_bus_arbiter
    import eight_bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] ack,
    input  logic       readyToAccept,
    input  logic       busError,
    output logic       dataReady,
    output logic [7:0] eightBitInp,
    output logic       errFlag,
    output logic       errSrc,
    output logic       timeoutFlag,
    input  logic       errClear
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic             grant_reg, grant_next;
    logic             last_served_reg, last_served_next;
    logic [7:0]       hold_reg, hold_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             err_flag_reg, err_flag_next;
    logic             err_src_reg, err_src_next;
    logic             timeout_flag_reg, timeout_flag_next;

    logic arb_id;
    logic arb_valid;
    logic bus_err_event;
    logic timeout_event;

    rr_arbiter2 u_rr (
        .req         (req),
        .last_served (last_served_reg),
        .grant_id    (arb_id),
        .grant_valid (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            grant_reg        <= 1'b0;
            last_served_reg  <= 1'b1;
            hold_reg         <= 8'd0;
            wait_cnt_reg     <= '0;
            err_flag_reg     <= 1'b0;
            err_src_reg      <= 1'b0;
            timeout_flag_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            grant_reg        <= grant_next;
            last_served_reg  <= last_served_next;
            hold_reg         <= hold_next;
            wait_cnt_reg     <= wait_cnt_next;
            err_flag_reg     <= err_flag_next;
            err_src_reg      <= err_src_next;
            timeout_flag_reg <= timeout_flag_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        grant_next        = grant_reg;
        last_served_next  = last_served_reg;
        hold_next         = hold_reg;
        wait_cnt_next     = wait_cnt_reg;
        err_flag_next     = err_flag_reg;
        err_src_next      = err_src_reg;
        timeout_flag_next = timeout_flag_reg;
        timeout_event     = 1'b0;
        bus_err_event     = busError && ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT));

        case (state_reg)
            ST_IDLE: begin
                // Requests are only looked at here, so a dropped request is simply never seen.
                if (arb_valid && readyToAccept) begin
                    grant_next       = arb_id;
                    last_served_next = arb_id;
                    hold_next        = arb_id ? data1 : data0;
                    state_next       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_next = '0;
                state_next    = ST_WAIT;
            end
            ST_WAIT: begin
                if (readyToAccept) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt_reg == CNT_LAST) begin
                    timeout_event = 1'b1;
                    state_next    = ST_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A fresh error beats a simultaneous clear; otherwise the first source sticks.
        if (bus_err_event || timeout_event) begin
            err_flag_next = 1'b1;
            if (!err_flag_reg || errClear) begin
                err_src_next = grant_reg;
            end
        end else if (errClear) begin
            err_flag_next = 1'b0;
            err_src_next  = 1'b0;
        end

        if (timeout_event) begin
            timeout_flag_next = 1'b1;
        end else if (errClear) begin
            timeout_flag_next = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign ack[gi] = (state_reg == ST_ISSUE) && (grant_reg == 1'(gi));
        end
    endgenerate

    assign dataReady   = (state_reg == ST_ISSUE);
    assign eightBitInp = hold_reg;
    assign errFlag     = err_flag_reg;
    assign errSrc      = err_src_reg;
    assign timeoutFlag = timeout_flag_reg;

endmodule

// File: tb/tb_eight_bus_arbiter.sv
// Scoreboarded bench: requesters hold per-id byte queues, expected issues are
// queued at stimulus time and checked by an independent monitor.
`timescale 1ns/1ps
module tb_eight_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] data0 = 8'd0;
    logic [7:0] data1 = 8'd0;
    logic [1:0] ack;
    logic       readyToAccept = 1'b0;
    logic       busError = 1'b0;
    logic       dataReady;
    logic [7:0] eightBitInp;
    logic       errFlag;
    logic       errSrc;
    logic       timeoutFlag;
    logic       errClear = 1'b0;

    typedef struct {
        logic       id;
        logic [7:0] b;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] feed0[$];
    logic [7:0] feed1[$];
    int         n_cmp = 0;
    int         n_err = 0;

    eight_bus_arbiter #(.TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .data0         (data0),
        .data1         (data1),
        .ack           (ack),
        .readyToAccept (readyToAccept),
        .busError      (busError),
        .dataReady     (dataReady),
        .eightBitInp   (eightBitInp),
        .errFlag       (errFlag),
        .errSrc        (errSrc),
        .timeoutFlag   (timeoutFlag),
        .errClear      (errClear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic push_tx(input logic id, input logic [7:0] b);
        exp_t e;
        e.id = id;
        e.b  = b;
        exp_q.push_back(e);
        if (id) feed1.push_back(b);
        else    feed0.push_back(b);
    endtask

    // Requesters: hold req and the head byte until acked, then move on.
    initial begin
        forever begin
            @(negedge clk);
            if (ack[0] && feed0.size() != 0) void'(feed0.pop_front());
            if (ack[1] && feed1.size() != 0) void'(feed1.pop_front());
            req[0] = (feed0.size() != 0);
            req[1] = (feed1.size() != 0);
            if (feed0.size() != 0) data0 = feed0[0];
            if (feed1.size() != 0) data1 = feed1[0];
        end
    end

    // Monitor: every strobe must match the oldest expected issue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (dataReady || ack != 2'b00) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got issue ack=%b byte=%02h, expected none", ack, eightBitInp);
                end else begin
                    e = exp_q.pop_front();
                    $display("issue id=%0d byte=%02h ack=%b", e.id, eightBitInp, ack);
                    chk("sb_strobe", 32'(dataReady), 32'd1);
                    chk("sb_byte", 32'(eightBitInp), 32'(e.b));
                    chk("sb_ack", 32'(ack), e.id ? 32'd2 : 32'd1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dataReady"}, 32'(dataReady), 32'd0);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_byte"}, 32'(eightBitInp), 32'd0);
        chk({tag, "_errFlag"}, 32'(errFlag), 32'd0);
        chk({tag, "_errSrc"}, 32'(errSrc), 32'd0);
        chk({tag, "_timeoutFlag"}, 32'(timeoutFlag), 32'd0);
    endtask

    task automatic wait_issue(input string tag);
        int k = 0;
        do begin
            @(negedge clk); #1;
            k++;
        end while (!dataReady && k < 60);
        chk({tag, "_issue_seen"}, 32'(dataReady), 32'd1);
    endtask

    task automatic drain(input string tag, input int bound);
        int k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            @(negedge clk); #1;
            k++;
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        #1;
    endtask

    // From an idle FSM with ready high: strobe must appear exactly one cycle after req.
    task automatic issue_exact(input string tag, input logic id, input logic [7:0] b);
        push_tx(id, b);
        @(negedge clk); #1;
        chk({tag, "_req"}, 32'(req), id ? 32'd2 : 32'd1);
        @(negedge clk); #1;
        chk({tag, "_dataReady"}, 32'(dataReady), 32'd1);
        chk({tag, "_byte"}, 32'(eightBitInp), 32'(b));
        chk({tag, "_ack"}, 32'(ack), id ? 32'd2 : 32'd1);
        @(negedge clk); #1;
        chk({tag, "_dataReady_off"}, 32'(dataReady), 32'd0);
        chk({tag, "_ack_off"}, 32'(ack), 32'd0);
        chk({tag, "_byte_hold"}, 32'(eightBitInp), 32'(b));
    endtask

    task automatic pulse_clear();
        errClear = 1'b1;
        @(negedge clk); #1;
        errClear = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        int n0, n1, zr, k;
        logic [7:0] b0[$];
        logic [7:0] b1[$];

        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check_reset_outputs("reset");

        // Single requester, exact latency and one-cycle strobe.
        readyToAccept = 1'b1;
        @(negedge clk); #1;
        issue_exact("single52", 1'b0, 8'd52);
        drain("single52", 50);

        // Both held after reset: 0 first, then strict alternation.
        do_reset();
        push_tx(1'b0, 8'd5);
        push_tx(1'b1, 8'd9);
        push_tx(1'b0, 8'd5);
        push_tx(1'b1, 8'd9);
        drain("alt", 100);

        // Random byte streams with bursty ready; expected order is a plain interleave.
        do_reset();
        n0 = $urandom_range(3, 9);
        n1 = $urandom_range(3, 9);
        for (int i = 0; i < n0; i++) b0.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < n1; i++) b1.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < n0 || i < n1; i++) begin
            if (i < n0) push_tx(1'b0, b0[i]);
            if (i < n1) push_tx(1'b1, b1[i]);
        end
        zr = 0;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge clk); #1;
            k++;
            if (zr >= 4 || $urandom_range(0, 3) != 0) begin
                readyToAccept = 1'b1;
                zr = 0;
            end else begin
                readyToAccept = 1'b0;
                zr++;
            end
        end
        readyToAccept = 1'b1;
        drain("random", 10);
        chk("random_errFlag", 32'(errFlag), 32'd0);
        chk("random_timeoutFlag", 32'(timeoutFlag), 32'd0);

        // Timeout: ready low from the issue cycle for 20 cycles.
        push_tx(1'b1, 8'h77);
        wait_issue("to");
        readyToAccept = 1'b0;
        for (int w = 1; w <= 20; w++) begin
            @(negedge clk); #1;
            if (w == 16) begin
                chk("to_flag_before", 32'(timeoutFlag), 32'd0);
                chk("to_err_before", 32'(errFlag), 32'd0);
            end
            if (w == 17) begin
                chk("to_timeoutFlag", 32'(timeoutFlag), 32'd1);
                chk("to_errFlag", 32'(errFlag), 32'd1);
                chk("to_errSrc", 32'(errSrc), 32'd1);
            end
        end
        readyToAccept = 1'b1;
        issue_exact("to_idle", 1'b0, 8'h12);
        drain("to", 20);
        chk("to_src_sticky", 32'(errSrc), 32'd1);
        pulse_clear();
        chk("to_clr_err", 32'(errFlag), 32'd0);
        chk("to_clr_timeout", 32'(timeoutFlag), 32'd0);

        // Bus error in WAIT of a requester-1 transfer.
        push_tx(1'b1, 8'h3C);
        wait_issue("be1");
        readyToAccept = 1'b0;
        @(negedge clk); #1;
        busError = 1'b1;
        @(negedge clk); #1;
        busError = 1'b0;
        readyToAccept = 1'b1;
        drain("be1", 20);
        chk("be1_errFlag", 32'(errFlag), 32'd1);
        chk("be1_errSrc", 32'(errSrc), 32'd1);
        chk("be1_timeoutFlag", 32'(timeoutFlag), 32'd0);

        // Later requester-0 error must not overwrite the source.
        push_tx(1'b0, 8'hC3);
        wait_issue("be0");
        busError = 1'b1;
        @(negedge clk); #1;
        busError = 1'b0;
        drain("be0", 20);
        chk("be0_errFlag", 32'(errFlag), 32'd1);
        chk("be0_errSrc", 32'(errSrc), 32'd1);

        // Clear together with a new requester-0 error: new error wins.
        push_tx(1'b0, 8'h5A);
        wait_issue("beclr");
        busError = 1'b1;
        errClear = 1'b1;
        @(negedge clk); #1;
        busError = 1'b0;
        errClear = 1'b0;
        drain("beclr", 20);
        chk("beclr_errFlag", 32'(errFlag), 32'd1);
        chk("beclr_errSrc", 32'(errSrc), 32'd0);
        pulse_clear();
        chk("clr_errFlag", 32'(errFlag), 32'd0);
        chk("clr_errSrc", 32'(errSrc), 32'd0);
        chk("clr_timeoutFlag", 32'(timeoutFlag), 32'd0);

        // Reset in the cycle after ISSUE aborts the transfer.
        push_tx(1'b0, 8'hA5);
        wait_issue("rstabort");
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        check_reset_outputs("rstabort");
        push_tx(1'b0, 8'h11);
        push_tx(1'b1, 8'h22);
        @(negedge clk); #1;
        chk("rstabort_hold_dataReady", 32'(dataReady), 32'd0);
        rst = 1'b0;
        drain("rst_both", 50);

        // Only requester 1 pending across reset.
        rst = 1'b1;
        push_tx(1'b1, 8'h33);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        drain("rst_one", 50);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
